button_conditioner: RTL and testbench

Input stage of the Pong paddle path. Takes the two raw, asynchronous, bouncing push-button levels for one player and converts them into clean, debounced, active-low button levels for the paddle stage. It also produces a one-cycle `moveTick` strobe that sets the paddle's step rate, so the paddle moves one pixel per tick rather than one per `clk`. Press-edge strobes are provided for game-start and serve logic.

---
 rtl/pong_pkg.sv | 15 +
 rtl/debounce_channel.sv | 63 ++++++
 rtl/button_conditioner.sv | 58 +++++
 tb/tb_button_conditioner.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared Pong constants and types
package pong_pkg;

    localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam int TICK_CYCLES_DEFAULT     = 250000;

    localparam int SCREEN_WIDTH  = 640;
    localparam int SCREEN_HEIGHT = 480;

    typedef enum logic {
        STABLE   = 1'b0,
        CHANGING = 1'b1
    } debounce_state_t;

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - synchronizer, debounce FSM and press strobe for one active-low button
module debounce_channel
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic clean,
    output logic press
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic            s1;
    logic            s2;
    logic [CW-1:0]   cnt;
    debounce_state_t state;

    // A bounce back to the committed level drops to STABLE, which restarts the count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b1;
            s2    <= 1'b1;
            state <= STABLE;
            cnt   <= '0;
            clean <= 1'b1;
            press <= 1'b0;
        end else begin
            s1    <= raw;
            s2    <= s1;
            press <= 1'b0;
            case (state)
                STABLE: begin
                    if (s2 != clean) begin
                        state <= CHANGING;
                        cnt   <= CW'(1);
                    end
                end
                CHANGING: begin
                    if (s2 == clean) begin
                        state <= STABLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_MAX) begin
                        clean <= s2;
                        press <= clean & ~s2;
                        cnt   <= '0;
                        state <= STABLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= STABLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced paddle buttons, press strobes and paddle step tick
module button_conditioner
    import pong_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int TICK_CYCLES     = TICK_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic upButtonRaw,
    input  logic downButtonRaw,
    output logic upButton,
    output logic downButton,
    output logic moveTick,
    output logic upPress,
    output logic downPress
);

    localparam int            TW       = $clog2(TICK_CYCLES);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_CYCLES - 1);

    logic [TW-1:0] tcnt;

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_up (
        .clk  (clk),
        .reset(reset),
        .raw  (upButtonRaw),
        .clean(upButton),
        .press(upPress)
    );

    debounce_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_down (
        .clk  (clk),
        .reset(reset),
        .raw  (downButtonRaw),
        .clean(downButton),
        .press(downPress)
    );

    // Free-running step rate, deliberately independent of button activity.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcnt     <= '0;
            moveTick <= 1'b0;
        end else if (tcnt == TICK_MAX) begin
            tcnt     <= '0;
            moveTick <= 1'b1;
        end else begin
            tcnt     <= tcnt + 1'b1;
            moveTick <= 1'b0;
        end
    end

endmodule

// File: tb/tb_button_conditioner.sv
// tb/tb_button_conditioner.sv - directed bench with a cycle-level behavioural model of button_conditioner
module tb_button_conditioner;

    localparam int D = 4;
    localparam int T = 5;

    logic clk = 1'b0;
    logic reset;
    logic up_raw;
    logic dn_raw;
    logic upButton, downButton, moveTick, upPress, downPress;

    int n_cmp  = 0;
    int n_fail = 0;

    button_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .TICK_CYCLES    (T)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .upButtonRaw  (up_raw),
        .downButtonRaw(dn_raw),
        .upButton     (upButton),
        .downButton   (downButton),
        .moveTick     (moveTick),
        .upPress      (upPress),
        .downPress    (downPress)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: two-sample delay, then a level is accepted once the delayed sample
    // has disagreed with the accepted level for D consecutive edges.
    logic m_s1[2]    = '{1'b1, 1'b1};
    logic m_s2[2]    = '{1'b1, 1'b1};
    logic m_clean[2] = '{1'b1, 1'b1};
    logic m_press[2] = '{1'b0, 1'b0};
    int   m_run[2]   = '{0, 0};
    int   m_edges    = 0;
    logic m_tick     = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_s1[c] = 1'b1; m_s2[c] = 1'b1; m_clean[c] = 1'b1;
                m_press[c] = 1'b0; m_run[c] = 0;
            end
            m_edges = 0;
            m_tick  = 1'b0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                m_press[c] = 1'b0;
                if (m_s2[c] != m_clean[c]) begin
                    m_run[c]++;
                    if (m_run[c] == D) begin
                        m_press[c] = (m_clean[c] == 1'b1);
                        m_clean[c] = m_s2[c];
                        m_run[c]   = 0;
                    end
                end else begin
                    m_run[c] = 0;
                end
                m_s2[c] = m_s1[c];
                m_s1[c] = (c == 0) ? up_raw : dn_raw;
            end
            m_edges++;
            m_tick = (m_edges % T == 0);
        end
    end

    always @(negedge clk) begin
        check("model_upButton",   upButton,   m_clean[0]);
        check("model_downButton", downButton, m_clean[1]);
        check("model_upPress",    upPress,    m_press[0]);
        check("model_downPress",  downPress,  m_press[1]);
        check("model_moveTick",   moveTick,   m_tick);
    end

    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        int pulses;
        reset  = 1'b1;
        up_raw = 1'b1;
        dn_raw = 1'b1;
        @(negedge clk);
        check("rst_upButton", upButton, 1'b1);
        check("rst_downButton", downButton, 1'b1);
        check("rst_moveTick", moveTick, 1'b0);
        check("rst_upPress", upPress, 1'b0);
        check("rst_downPress", downPress, 1'b0);

        // Tick: release just after an edge, next edge is edge 1
        @(posedge clk); #2 reset = 1'b0;
        pulses = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            check($sformatf("tick_edge%0d", n), moveTick, (n % 5 == 0) ? 1'b1 : 1'b0);
            if (moveTick) pulses++;
        end
        check("tick_count_is_20", (pulses == 20), 1'b1);

        // Clean press: first sampled at edge 0, commit at edge 5
        #1 up_raw = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("press_up_e%0d", i), upButton, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("press_upPress_e%0d", i), upPress, (i == 5) ? 1'b1 : 1'b0);
            check("press_down_idle", downButton, 1'b1);
        end
        @(posedge clk); #1;
        check("press_strobe_width", upPress, 1'b0);
        check("press_up_held", upButton, 1'b0);

        // Release: rises 5 edges later, no strobe
        up_raw = 1'b1;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("release_up_e%0d", i), upButton, (i < 5) ? 1'b0 : 1'b1);
            check("release_no_press", upPress, 1'b0);
        end

        // Bounce: 2-cycle segments never survive D=4
        for (int j = 0; j < 10; j++) begin
            dn_raw = (j % 2 == 0) ? 1'b0 : 1'b1;
            wait_edges(2);
            check("bounce_down_held", downButton, 1'b1);
            check("bounce_no_press", downPress, 1'b0);
        end
        dn_raw = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("bounce_down_e%0d", i), downButton, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("bounce_downPress_e%0d", i), downPress, (i == 5) ? 1'b1 : 1'b0);
        end
        @(posedge clk); #1;
        check("bounce_strobe_width", downPress, 1'b0);
        dn_raw = 1'b1;
        wait_edges(8);

        // Async reset with both held low, then re-acceptance after full latency
        up_raw = 1'b0;
        dn_raw = 1'b0;
        wait_edges(8);
        check("held_up_low", upButton, 1'b0);
        check("held_down_low", downButton, 1'b0);
        #1 reset = 1'b1;
        #1;
        check("async_rst_upButton", upButton, 1'b1);
        check("async_rst_downButton", downButton, 1'b1);
        check("async_rst_moveTick", moveTick, 1'b0);
        check("async_rst_upPress", upPress, 1'b0);
        check("async_rst_downPress", downPress, 1'b0);
        @(posedge clk); #2 reset = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("reaccept_up_e%0d", i), upButton, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("reaccept_upPress_e%0d", i), upPress, (i == 5) ? 1'b1 : 1'b0);
        end
        up_raw = 1'b1;
        dn_raw = 1'b1;
        wait_edges(8);

        // Reset mid-debounce (cnt=2 after edge k+3), then simultaneous press
        up_raw = 1'b0;
        wait_edges(4);
        reset  = 1'b1;
        up_raw = 1'b1;
        #1 check("middeb_rst_up", upButton, 1'b1);
        @(posedge clk); #2 reset = 1'b0;
        wait_edges(8);
        check("middeb_no_commit", upButton, 1'b1);
        up_raw = 1'b0;
        dn_raw = 1'b0;
        for (int i = 0; i <= 5; i++) begin
            @(posedge clk); #1;
            check($sformatf("both_up_e%0d", i), upButton, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("both_down_e%0d", i), downButton, (i < 5) ? 1'b1 : 1'b0);
            check($sformatf("both_upPress_e%0d", i), upPress, (i == 5) ? 1'b1 : 1'b0);
            check($sformatf("both_downPress_e%0d", i), downPress, (i == 5) ? 1'b1 : 1'b0);
        end
        wait_edges(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
